// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ISA opcode encodings and condition-flag bit positions.
package cpu_pkg;

  // Full ISA opcode list; the conditional branches occupy 5'b10011..5'b10110.
  localparam logic [4:0] NOP  = 5'b00000;
  localparam logic [4:0] ADD  = 5'b00001;
  localparam logic [4:0] SUB  = 5'b00010;
  localparam logic [4:0] AND_ = 5'b00011;
  localparam logic [4:0] OR_  = 5'b00100;
  localparam logic [4:0] XOR_ = 5'b00101;
  localparam logic [4:0] SHL  = 5'b00110;
  localparam logic [4:0] SHR  = 5'b00111;
  localparam logic [4:0] LD   = 5'b01000;
  localparam logic [4:0] ST   = 5'b01001;
  localparam logic [4:0] LDI  = 5'b01010;
  localparam logic [4:0] CMP  = 5'b01011;
  localparam logic [4:0] JMP  = 5'b10000;
  localparam logic [4:0] JAL  = 5'b10001;
  localparam logic [4:0] JR   = 5'b10010;
  localparam logic [4:0] BEQ  = 5'b10011;
  localparam logic [4:0] BLT  = 5'b10100;
  localparam logic [4:0] BGT  = 5'b10101;
  localparam logic [4:0] BNE  = 5'b10110;
  localparam logic [4:0] HALT = 5'b11111;

  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_N = 0;

endpackage

// File: rtl/branch_logic.sv
// Branch-condition resolver: decides whether the current conditional branch is
// taken and presents the registered PC-mux select one cycle later.
import cpu_pkg::*;

module branch_logic (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] opcode,
  input  logic [1:0] flags,
  output logic       pc_branch_sel_out
);

  logic take_s;
  logic sel_r;

  // Take decision; BLT/BGT look only at N, so equal operands count as "greater".
  always_comb begin
    take_s = 1'b0;
    case (opcode)
      BEQ:     take_s = flags[FLAG_Z];
      BNE:     take_s = ~flags[FLAG_Z];
      BLT:     take_s = flags[FLAG_N];
      BGT:     take_s = ~flags[FLAG_N];
      default: take_s = 1'b0;
    endcase
  end

  // Output register, cleared immediately on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_r <= 1'b0;
    end else begin
      sel_r <= take_s;
    end
  end

  assign pc_branch_sel_out = sel_r;

endmodule

// File: tb/tb_branch_logic.sv
// Self-checking bench for branch_logic: vector table, hand-written reset and
// latency sequences, and randomized traffic against a behavioural model.
module tb_branch_logic;

  logic       clk;
  logic       rst_n;
  logic [4:0] opcode;
  logic [1:0] flags;
  logic       pc_branch_sel_out;

  int n_checks = 0;
  int n_fail   = 0;

  branch_logic dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .opcode            (opcode),
    .flags             (flags),
    .pc_branch_sel_out (pc_branch_sel_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] op;
    logic [1:0] fl;
    logic       exp;
  } vec_t;

  // Reference: a branch is taken when the flag-derived relation matches the opcode's test.
  function automatic logic model_take(input logic [4:0] op, input logic [1:0] fl);
    logic eq;
    logic lt;
    eq = fl[1];
    lt = fl[0];
    if (op == 5'b10011) return eq;
    if (op == 5'b10110) return !eq;
    if (op == 5'b10100) return lt;
    if (op == 5'b10101) return !lt;
    return 1'b0;
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];
  logic [4:0] branch_ops[4];

  initial begin
    rst_n  = 1'b0;
    opcode = 5'b10011;
    flags  = 2'b10;
    #1;
    check("reset_t0", pc_branch_sel_out, 1'b0);

    for (int i = 0; i < 5; i++) begin
      step();
      check("reset_hold", pc_branch_sel_out, 1'b0);
    end
    rst_n = 1'b1;
    step();
    check("reset_release", pc_branch_sel_out, 1'b1);

    vecs = '{
      '{5'b10011, 2'b10, 1'b1}, '{5'b10011, 2'b11, 1'b1},
      '{5'b10011, 2'b01, 1'b0}, '{5'b10011, 2'b00, 1'b0},
      '{5'b10110, 2'b01, 1'b1}, '{5'b10110, 2'b00, 1'b1},
      '{5'b10110, 2'b11, 1'b0}, '{5'b10110, 2'b10, 1'b0},
      '{5'b10100, 2'b01, 1'b1}, '{5'b10100, 2'b11, 1'b1},
      '{5'b10100, 2'b10, 1'b0}, '{5'b10100, 2'b00, 1'b0},
      '{5'b10101, 2'b00, 1'b1}, '{5'b10101, 2'b10, 1'b1},
      '{5'b10101, 2'b01, 1'b0}, '{5'b10101, 2'b11, 1'b0},
      '{5'b00000, 2'b00, 1'b0}, '{5'b00000, 2'b01, 1'b0},
      '{5'b00000, 2'b10, 1'b0}, '{5'b00000, 2'b11, 1'b0},
      '{5'b10111, 2'b00, 1'b0}, '{5'b10111, 2'b01, 1'b0},
      '{5'b10111, 2'b10, 1'b0}, '{5'b10111, 2'b11, 1'b0}
    };
    foreach (vecs[i]) begin
      opcode = vecs[i].op;
      flags  = vecs[i].fl;
      step();
      step();
      check($sformatf("vec%0d_op%b_fl%b", i, vecs[i].op, vecs[i].fl),
            pc_branch_sel_out, vecs[i].exp);
    end

    // BEQ taken, then BNE with the same flags: output must fall exactly one edge later.
    opcode = 5'b10011;
    flags  = 2'b10;
    step();
    step();
    check("switch_pre", pc_branch_sel_out, 1'b1);
    opcode = 5'b10110;
    #2;
    check("switch_no_comb_path", pc_branch_sel_out, 1'b1);
    step();
    check("switch_one_edge", pc_branch_sel_out, 1'b0);

    // Mid-cycle async reset pulse with a taken branch in flight.
    opcode = 5'b10100;
    flags  = 2'b01;
    step();
    check("pulse_pre", pc_branch_sel_out, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("pulse_async_drop", pc_branch_sel_out, 1'b0);
    #1;
    rst_n = 1'b1;
    #1;
    check("pulse_held_until_edge", pc_branch_sel_out, 1'b0);
    step();
    check("pulse_first_edge", pc_branch_sel_out, 1'b1);

    // Randomized traffic, inputs changing every cycle.
    branch_ops = '{5'b10011, 5'b10100, 5'b10101, 5'b10110};
    for (int i = 0; i < 400; i++) begin
      logic [4:0] op;
      logic [1:0] fl;
      if ($urandom_range(0, 3) != 0) op = branch_ops[$urandom_range(0, 3)];
      else                           op = 5'($urandom);
      fl = 2'($urandom);
      opcode = op;
      flags  = fl;
      step();
      check($sformatf("rand%0d_op%b_fl%b", i, op, fl), pc_branch_sel_out, model_take(op, fl));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
